// File: rtl/seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// seq_pkg : shared encodings and defaults for the 1001 frame transmitter
//           and its reference detector.   Rev 1.0
// ============================================================================
package seq_pkg;

    localparam int C_WIDTH_DEF = 16;
    localparam int C_LEN_W_DEF = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_DONE  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        DET_S0   = 2'd0,
        DET_S1   = 2'd1,
        DET_S10  = 2'd2,
        DET_S100 = 2'd3
    } det_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_1001_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// seq_1001_model : non-overlapping Mealy 1001 detector (golden reference).
//                  Rev 1.0
// ============================================================================
module seq_1001_model
    import seq_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic y
);

    det_state_e state_q;
    det_state_e state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DET_S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = DET_S0;
        end else if (en) begin
            case (state_q)
                DET_S0:   state_d = x ? DET_S1   : DET_S0;
                DET_S1:   state_d = x ? DET_S1   : DET_S10;
                DET_S10:  state_d = x ? DET_S1   : DET_S100;
                // A match consumes the trailing 1, so both arcs restart at S0.
                DET_S100: state_d = DET_S0;
                default:  state_d = DET_S0;
            endcase
        end
    end

    assign y = en && (state_q == DET_S100) && x;

endmodule
`default_nettype wire

// File: rtl/seq_1001_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// seq_1001_tx : serialises a len-bit frame MSB first and reports the expected
//               1001 detector output and per-frame match count.   Rev 1.0
// ============================================================================
module seq_1001_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEF,
    parameter int LEN_W = C_LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len,
    output logic             xout,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             y_exp,
    output logic [7:0]       match_cnt
);

    localparam logic [LEN_W-1:0] C_WIDTH_L = LEN_W'(WIDTH);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             xout_q, xout_d;
    logic [7:0]       match_cnt_q, match_cnt_d;

    logic             w_accept;
    logic             w_valid;
    logic             w_y;
    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W-1:0] w_pad;
    logic [WIDTH-1:0] w_aligned;

    // Left-justify the len-bit window so the first bit to send sits at the MSB.
    assign w_len_eff = (len > C_WIDTH_L) ? C_WIDTH_L : len;
    assign w_pad     = C_WIDTH_L - w_len_eff;
    assign w_aligned = data_in << w_pad;
    assign w_valid   = (state_q == TX_SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= TX_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            xout_q      <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            xout_q      <= xout_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        xout_d      = 1'b0;
        w_accept    = 1'b0;
        match_cnt_d = match_cnt_q;

        case (state_q)
            TX_IDLE: begin
                if (load) begin
                    w_accept = 1'b1;
                    if (w_len_eff == '0) begin
                        state_d = TX_DONE;
                    end else begin
                        state_d = TX_SHIFT;
                        xout_d  = w_aligned[WIDTH-1];
                        shreg_d = w_aligned << 1;
                        cnt_d   = w_len_eff - LEN_W'(1);
                    end
                end
            end
            TX_SHIFT: begin
                // cnt_q holds the bits still to send after the one on xout.
                if (cnt_q == '0) begin
                    state_d = TX_DONE;
                end else begin
                    xout_d  = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - LEN_W'(1);
                end
            end
            TX_DONE: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (w_accept) begin
            match_cnt_d = '0;
        end else if (w_y && (match_cnt_q != 8'hFF)) begin
            match_cnt_d = match_cnt_q + 8'd1;
        end
    end

    seq_1001_model u_model (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_accept),
        .en      (w_valid),
        .x       (xout_q),
        .y       (w_y)
    );

    assign xout      = xout_q;
    assign valid     = w_valid;
    assign busy      = w_valid;
    assign done      = (state_q == TX_DONE);
    assign y_exp     = w_y;
    assign match_cnt = match_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_1001_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_seq_1001_tx : directed frames checked cycle by cycle against a
//                  bit-list model of the transmitter and 1001 detector.
// ============================================================================
module tb_seq_1001_tx;

    localparam int W  = 16;
    localparam int LW = 5;

    typedef struct packed {
        logic       v;
        logic       x;
        logic       y;
        logic       b;
        logic       d;
        logic [7:0] c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load;
    logic [W-1:0]  data_in;
    logic [LW-1:0] len;
    logic          xout, valid, busy, done, y_exp;
    logic [7:0]    match_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        q[$];
    exp_t        e;
    logic [7:0]  m_held = 8'd0;
    logic        idle_now;
    logic [12:0] act;
    int          since_load = 0;

    logic [15:0] obs_x;
    logic [15:0] obs_y;
    int          obs_n;
    logic        done_seen;
    int          done_lat;

    seq_1001_tx #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .data_in   (data_in),
        .len       (len),
        .xout      (xout),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .y_exp     (y_exp),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Expected per-cycle timeline of one frame: window search over the sent
    // bits, restarting the window after every hit.
    task automatic build(input logic [15:0] d, input logic [4:0] l);
        int   n;
        int   since;
        int   c;
        logic [3:0] win;
        exp_t ent;
        n     = (l > 5'd16) ? 16 : int'(l);
        since = 0;
        c     = 0;
        win   = 4'b0;
        for (int j = 0; j < n; j++) begin
            logic bit_j;
            bit_j = d[n-1-j];
            win   = {win[2:0], bit_j};
            since++;
            ent = '{v:1'b1, x:bit_j, y:1'b0, b:1'b1, d:1'b0, c:8'(c)};
            if (since >= 4 && win == 4'b1001) begin
                ent.y = 1'b1;
                since = 0;
                if (c < 255) c++;
            end
            q.push_back(ent);
        end
        q.push_back('{v:1'b0, x:1'b0, y:1'b0, b:1'b0, d:1'b1, c:8'(c)});
    endtask

    always @(negedge clk) begin
        act = {valid, xout, y_exp, busy, done, match_cnt};
        if (!reset_n) begin
            q.delete();
            m_held = 8'd0;
            chk("in_reset", 32'(act), 32'd0);
        end else begin
            since_load++;
            if (q.size() > 0) begin
                e        = q.pop_front();
                m_held   = e.c;
                idle_now = 1'b0;
            end else begin
                e        = '{v:1'b0, x:1'b0, y:1'b0, b:1'b0, d:1'b0, c:m_held};
                idle_now = 1'b1;
            end
            chk("cycle", 32'(act), 32'(e));
            if (valid) begin
                obs_x = {obs_x[14:0], xout};
                obs_y = {obs_y[14:0], y_exp};
                obs_n++;
            end
            if (done) begin
                done_seen = 1'b1;
                done_lat  = since_load;
            end
            if (idle_now && load) begin
                build(data_in, len);
                since_load = 0;
            end
        end
    end

    task automatic run_frame(input string name, input logic [15:0] d, input logic [4:0] l,
                             input logic [15:0] ex_x, input logic [15:0] ex_y, input int ex_n,
                             input int ex_cnt, input int ex_lat, input bit pulse_mid);
        @(posedge clk); #2;
        obs_x = '0; obs_y = '0; obs_n = 0; done_seen = 1'b0; done_lat = 0;
        load = 1'b1; data_in = d; len = l;
        @(posedge clk); #2;
        load = 1'b0; data_in = 16'($urandom); len = 5'($urandom_range(0, 20));
        if (pulse_mid) begin
            @(posedge clk); #2;
            load = 1'b1; data_in = 16'hFFFF; len = 5'd16;
            @(posedge clk); #2;
            load = 1'b0;
            chk({name, "_busy_mid"}, 32'(busy), 32'd1);
        end
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge clk); #1;
        end
        chk({name, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({name, "_xbits"}, 32'(obs_x), 32'(ex_x));
        chk({name, "_ybits"}, 32'(obs_y), 32'(ex_y));
        chk({name, "_nvalid"}, 32'(obs_n), 32'(ex_n));
        chk({name, "_latency"}, 32'(done_lat), 32'(ex_lat));
        chk({name, "_match_cnt"}, 32'(match_cnt), 32'(ex_cnt));
        repeat (2) @(posedge clk);
        #2;
        chk({name, "_cnt_hold"}, 32'(match_cnt), 32'(ex_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        load = 1'b0; data_in = '0; len = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #0.1;
        chk("reset_outputs", 32'({valid, xout, y_exp, busy, done, match_cnt}), 32'd0);
        #0.05 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("idle_outputs", 32'({valid, xout, y_exp, busy, done, match_cnt}), 32'd0);

        run_frame("f9009",  16'h9009, 5'd16, 16'h9009, 16'h1001, 16, 2, 17, 1'b0);
        run_frame("f1249",  16'h1249, 5'd16, 16'h1249, 16'h0208, 16, 2, 17, 1'b0);
        run_frame("f0009",  16'h0009, 5'd4,  16'h0009, 16'h0001, 4,  1, 5,  1'b1);
        run_frame("len0",   16'hFFFF, 5'd0,  16'h0000, 16'h0000, 0,  0, 1,  1'b0);
        run_frame("len20",  16'h9009, 5'd20, 16'h9009, 16'h1001, 16, 2, 17, 1'b0);
        run_frame("f00c9",  16'h00C9, 5'd7,  16'h0049, 16'h0008, 7,  1, 8,  1'b0);

        // Abort an all-ones frame at its fifth bit.
        @(posedge clk); #2;
        done_seen = 1'b0;
        load = 1'b1; data_in = 16'hFFFF; len = 5'd16;
        @(posedge clk); #2;
        load = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("abort_bit5_live", 32'({valid, xout, busy}), 32'b111);
        reset_n = 1'b0;
        #1;
        chk("abort_clear", 32'({valid, xout, y_exp, busy, done, match_cnt}), 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        run_frame("after_abort", 16'h9009, 5'd16, 16'h9009, 16'h1001, 16, 2, 17, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
